// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronises and filters ps2_clk, then deserialises
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) into bytes.
// Bad frames and stalled frames are dropped, and each drop raises a one-cycle
// error pulse.
// Optional feature macro PS2_RX_FIFO_EN: when it is defined, the output queue
// is a 2^FIFO_BITS-entry first-word-fall-through FIFO. When it is undefined,
// the queue is a single holding register.
module ps2_host_rx #(
   parameter int unsigned FILTER    = 4,
   parameter int unsigned TIMEOUT   = 50000,
   parameter int unsigned FIFO_BITS = 3
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       err_parity,
   output logic       err_frame,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic       busy
);

   localparam int unsigned TW        = $clog2(TIMEOUT + 1);
   localparam logic [3:0]  FILT_LAST = 4'(FILTER - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic          filt_q, filt_d;
   logic [3:0]    filt_cnt_q, filt_cnt_d;
   logic          fe_q, fe_d;
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          push, perr, ferr, terr, ovr;
   logic          err_parity_q, err_frame_q, err_timeout_q, err_overrun_q;

   // Two-flop synchronisers; both lines idle high
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= ps2_clk;
         clk_sync_q <= clk_meta_q;
         dat_meta_q <= ps2_data;
         dat_sync_q <= dat_meta_q;
      end
   end

   // Glitch filter: flip only on the FILTER-th consecutive differing sample
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = 4'd0;
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == FILT_LAST) filt_d = ~filt_q;
         else                         filt_cnt_d = filt_cnt_q + 4'd1;
      end
      fe_d = filt_q & ~filt_d;
   end

   // Filter state and registered falling-edge strobe
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= 4'd0;
         fe_q       <= 1'b0;
      end else begin
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
         fe_q       <= fe_d;
      end
   end

   // Frame FSM next state; the timeout wins over an fe in the same cycle
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      push      = 1'b0;
      perr      = 1'b0;
      ferr      = 1'b0;
      terr      = 1'b0;
      if (state_q != S_IDLE && idle_cnt_q == TMO_LAST) begin
         terr      = 1'b1;
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
         shift_d   = 8'h00;
      end else if (fe_q) begin
         unique case (state_q)
            S_IDLE: begin
               if (!dat_sync_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {dat_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_ok_d = (^shift_q) ^ dat_sync_q;
               state_d  = S_STOP;
            end
            S_STOP: begin
               if (!dat_sync_q)  ferr = 1'b1;
               else if (par_ok_q) push = 1'b1;
               else               perr = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (terr || fe_q || state_q == S_IDLE) idle_cnt_d = '0;
      else                                   idle_cnt_d = idle_cnt_q + 1'b1;
   end

   // Frame FSM registers and frame-error pulse registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         bit_cnt_q     <= 3'd0;
         shift_q       <= 8'h00;
         par_ok_q      <= 1'b0;
         idle_cnt_q    <= '0;
         err_parity_q  <= 1'b0;
         err_frame_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         par_ok_q      <= par_ok_d;
         idle_cnt_q    <= idle_cnt_d;
         err_parity_q  <= perr;
         err_frame_q   <= ferr;
         err_timeout_q <= terr;
      end
   end

`ifdef PS2_RX_FIFO_EN
   localparam int unsigned DEPTH = 1 << FIFO_BITS;

   logic [7:0]           mem_q [DEPTH];
   logic [FIFO_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_BITS:0]   count_q, count_d;
   logic                 pop, full, wr_en;

   // A pop frees a slot in the same cycle, so a push on a full FIFO still fits
   always_comb begin
      pop     = rx_ack && (count_q != '0);
      full    = (count_q == (FIFO_BITS + 1)'(DEPTH));
      wr_en   = push && (!full || pop);
      ovr     = push && full && !pop;
      count_d = count_q;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
   end

   // Storage array; no reset so it can map onto RAM
   always_ff @(posedge clk_sys) begin
      if (wr_en) mem_q[wr_ptr_q] <= shift_q;
   end

   // Pointers wrap naturally at the FIFO depth
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         err_overrun_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q       <= count_d;
         err_overrun_q <= ovr;
      end
   end

   assign rx_valid = (count_q != '0);
   assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
`else
   logic [7:0] hold_data_q;
   logic       hold_valid_q;

   // FIFO_BITS only sizes the optional FIFO
   if (FIFO_BITS == 0) begin : g_no_fifo
   end

   // A same-cycle ack frees the register, so the new byte replaces the old one
   always_comb begin
      ovr = push && hold_valid_q && !rx_ack;
   end

   // Single holding register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hold_data_q   <= 8'h00;
         hold_valid_q  <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         if (push && (!hold_valid_q || rx_ack)) begin
            hold_data_q  <= shift_q;
            hold_valid_q <= 1'b1;
         end else if (rx_ack && hold_valid_q) begin
            hold_valid_q <= 1'b0;
         end
         err_overrun_q <= ovr;
      end
   end

   assign rx_valid = hold_valid_q;
   assign rx_data  = hold_data_q;
`endif

   assign err_parity  = err_parity_q;
   assign err_frame   = err_frame_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: drives PS/2 frames at 10 kHz against a
// 400 kHz clk_sys, scoreboards good bytes and counts error pulses.
`timescale 1ns/1ps
module tb_ps2_host_rx;

   localparam int HALF = 20;   // clk_sys cycles per PS/2 clock phase
   localparam int TMO  = 100;

   logic       clk_sys = 1'b0;
   logic       reset_n, ps2_clk, ps2_data, rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid, err_parity, err_frame, err_timeout, err_overrun, busy;

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   int   perr_c = 0, ferr_c = 0, terr_c = 0, oerr_c = 0;
   int   s_p, s_f, s_t, s_o;
   logic busy_prev  = 1'b0;
   logic fall_valid = 1'b0;
   int   k;

   always #1250 clk_sys = ~clk_sys;

   ps2_host_rx #(.FILTER(4), .TIMEOUT(TMO), .FIFO_BITS(3)) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ack      (rx_ack),
      .err_parity  (err_parity),
      .err_frame   (err_frame),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
      .busy        (busy)
   );

   // Count error-pulse cycles and remember rx_valid at each busy falling edge
   always @(negedge clk_sys) begin
      if (err_parity)  perr_c <= perr_c + 1;
      if (err_frame)   ferr_c <= ferr_c + 1;
      if (err_timeout) terr_c <= terr_c + 1;
      if (err_overrun) oerr_c <= oerr_c + 1;
      busy_prev <= busy;
      if (busy_prev && !busy) fall_valid <= rx_valid;
   end

   initial begin
      #250_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic pflip,
                                        input logic stop);
      return {stop, (~^d) ^ pflip, d, 1'b0};
   endfunction

   // Send the first n bits of f, LSB first; glitch_at inserts a one-cycle
   // low pulse on ps2_clk during the high phase of that bit
   task automatic send_raw(input logic [10:0] f, input int n, input int glitch_at);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         if (i == glitch_at) begin
            cyc(8);
            ps2_clk = 1'b0;
            cyc(1);
            ps2_clk = 1'b1;
            cyc(HALF - 9);
         end else begin
            cyc(HALF);
         end
         ps2_clk = 1'b0;
         cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [10:0] f);
      send_raw(f, 11, -1);
      cyc(HALF);
   endtask

   task automatic snap();
      s_p = perr_c; s_f = ferr_c; s_t = terr_c; s_o = oerr_c;
   endtask

   task automatic chk_err(input string tag, input int p, input int f, input int t, input int o);
      chk(tag, {8'(perr_c - s_p), 8'(ferr_c - s_f), 8'(terr_c - s_t), 8'(oerr_c - s_o)},
          {8'(p), 8'(f), 8'(t), 8'(o)});
   endtask

   task automatic expect_head(input string tag);
      logic [7:0] e;
      chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_data"}, 32'(rx_data), 32'(e));
      end
   endtask

   task automatic ack();
      rx_ack = 1'b1;
      cyc(1);
      rx_ack = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rx_ack   = 1'b0;
      cyc(3);
      chk("reset_outputs",
          {19'd0, rx_valid, busy, err_parity, err_frame, err_timeout, err_overrun, rx_data},
          32'd0);
      reset_n = 1'b1;
      cyc(5);

      // 1: good frame 0x1C, valid in the cycle busy drops, then ack
      snap();
      send_frame(frame(8'h1C, 1'b0, 1'b1));
      exp_q.push_back(8'h1C);
      chk("t1_valid_with_busy_fall", 32'(fall_valid), 32'd1);
      expect_head("t1");
      chk_err("t1_no_errors", 0, 0, 0, 0);
      ack();
      chk("t1_valid_after_ack", 32'(rx_valid), 32'd0);

      // 2: 0xF0 with wrong parity
      snap();
      send_frame(frame(8'hF0, 1'b1, 1'b1));
      chk_err("t2_parity_pulse", 1, 0, 0, 0);
      chk("t2_valid", 32'(rx_valid), 32'd0);
      chk("t2_busy", 32'(busy), 32'd0);

      // 3: 0x00 with stop 0, then good 0x5A
      snap();
      send_frame(frame(8'h00, 1'b0, 1'b0));
      chk_err("t3_frame_pulse", 0, 1, 0, 0);
      chk("t3_valid", 32'(rx_valid), 32'd0);
      snap();
      send_frame(frame(8'h5A, 1'b0, 1'b1));
      exp_q.push_back(8'h5A);
      expect_head("t3");
      chk_err("t3_good_no_errors", 0, 0, 0, 0);
      ack();

      // 4: start + 3 data bits, then clock parked high until timeout
      snap();
      send_raw(frame(8'hAA, 1'b0, 1'b1), 4, -1);
      chk("t4_busy_partial", 32'(busy), 32'd1);
      k = HALF;
      while (!err_timeout && k < 200) begin
         cyc(1);
         k++;
      end
      $display("t4: err_timeout seen %0d cycles after last ps2_clk fall", k);
      // window covers the synchroniser, filter and pulse register latency
      chk("t4_timeout_latency_window", 32'(k >= TMO && k <= TMO + 8), 32'd1);
      cyc(2);
      chk("t4_busy_after_timeout", 32'(busy), 32'd0);
      chk_err("t4_timeout_pulse", 0, 0, 1, 0);
      chk("t4_valid", 32'(rx_valid), 32'd0);
      send_frame(frame(8'hAA, 1'b0, 1'b1));
      exp_q.push_back(8'hAA);
      expect_head("t4");
      ack();

      // 5: overrun without ack
`ifdef PS2_RX_FIFO_EN
      snap();
      for (int i = 1; i <= 8; i++) begin
         send_frame(frame(8'(i), 1'b0, 1'b1));
         exp_q.push_back(8'(i));
      end
      chk_err("t5_no_overrun_first8", 0, 0, 0, 0);
      send_frame(frame(8'h09, 1'b0, 1'b1));
      chk_err("t5_overrun_on_9", 0, 0, 0, 1);
      for (int i = 1; i <= 8; i++) begin
         expect_head("t5_pop");
         ack();
      end
      chk("t5_empty_after_pops", 32'(rx_valid), 32'd0);
`else
      snap();
      send_frame(frame(8'h11, 1'b0, 1'b1));
      exp_q.push_back(8'h11);
      chk_err("t5_no_overrun_first", 0, 0, 0, 0);
      send_frame(frame(8'h22, 1'b0, 1'b1));
      chk_err("t5_overrun_second", 0, 0, 0, 1);
      expect_head("t5");
      ack();
      chk("t5_valid_after_ack", 32'(rx_valid), 32'd0);
`endif

      // 6: glitch mid-frame must not add a bit
      snap();
      send_raw(frame(8'h3C, 1'b0, 1'b1), 11, 4);
      cyc(HALF);
      exp_q.push_back(8'h3C);
      expect_head("t6_glitch");
      chk_err("t6_glitch_no_errors", 0, 0, 0, 0);

      // reset mid-frame while a byte is still held
      send_raw(frame(8'h3C, 1'b0, 1'b1), 5, -1);
      chk("t6_pre_reset", {30'd0, rx_valid, busy}, 32'h3);
      reset_n = 1'b0;
      #1;
      chk("t6_async_reset_outputs",
          {19'd0, rx_valid, busy, err_parity, err_frame, err_timeout, err_overrun, rx_data},
          32'd0);
      cyc(3);
      reset_n = 1'b1;
      cyc(5);
      snap();
      send_frame(frame(8'h3C, 1'b0, 1'b1));
      exp_q.push_back(8'h3C);
      expect_head("t6_after_reset");
      chk_err("t6_after_reset_no_errors", 0, 0, 0, 0);
      ack();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
